// File: rtl/acc_core.sv
// Streaming unsigned accumulator: sums valid samples while run_i is high, then strobes valid_o.
// Build option: define ACC_CORE_SATURATE_EN to clamp on overflow instead of wrapping.
module acc_core #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_DATA_WIDTH-1:0] number_i,
  input  logic                     valid_i,
  input  logic                     run_i,
  output logic                     valid_o,
  output logic [DWIDTH-1:0]        result_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic [DWIDTH-1:0] sample_ext;
  logic [DWIDTH-1:0] acc_add;

  assign sample_ext = DWIDTH'(number_i);

`ifdef ACC_CORE_SATURATE_EN
  logic [DWIDTH:0] sum_full;
  assign sum_full = {1'b0, acc_q} + {1'b0, sample_ext};
  // Once clamped, any further non-zero add carries out again, so the value sticks.
  assign acc_add  = sum_full[DWIDTH] ? {DWIDTH{1'b1}} : sum_full[DWIDTH-1:0];
`else
  assign acc_add  = acc_q + sample_ext;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StRun;
          // Starting a run discards the previous total.
          acc_d   = valid_i ? sample_ext : '0;
        end
      end
      StRun: begin
        if (!run_i) begin
          state_d = StDone;
        end else if (valid_i) begin
          acc_d = acc_add;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  assign valid_o  = (state_q == StDone);
  assign result_o = acc_q;

endmodule

// File: tb/tb_acc_core.sv
// Directed self-checking bench for acc_core with hand-computed expected sums.
module tb_acc_core;

  logic        clk;
  logic        rst;
  logic [7:0]  number_i;
  logic        valid_i;
  logic        run_i;
  logic        valid_o;
  logic [15:0] result_o;

  int n_checks;
  int n_errors;
  int pulses;

  acc_core #(
    .IN_DATA_WIDTH(8),
    .DWIDTH       (16)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .number_i(number_i),
    .valid_i (valid_i),
    .run_i   (run_i),
    .valid_o (valid_o),
    .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one edge, then settle and count completion strobes.
  task automatic step(input logic r, input logic v, input logic [7:0] n);
    run_i    = r;
    valid_i  = v;
    number_i = n;
    @(posedge clk);
    #1;
    if (valid_o) pulses++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    pulses   = 0;
    rst      = 1'b0;
    run_i    = 1'b0;
    valid_i  = 1'b0;
    number_i = 8'd0;

    // Reset state
    do_reset();
    check("reset_result", 32'(result_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);

    // valid_i in IDLE is ignored
    step(1'b0, 1'b1, 8'd50);
    check("idle_ignore", 32'(result_o), 32'd0);

    // Basic run: 0,1..100
    pulses = 0;
    step(1'b1, 1'b1, 8'd0);
    for (int i = 1; i <= 100; i++) step(1'b1, 1'b1, 8'(i));
    step(1'b1, 1'b0, 8'd77);
    check("basic_no_early_valid", 32'(valid_o), 32'd0);
    check("basic_sum_pre", 32'(result_o), 32'd5050);
    step(1'b0, 1'b0, 8'd0);
    check("basic_done_valid", 32'(valid_o), 32'd1);
    check("basic_done_sum", 32'(result_o), 32'd5050);
    step(1'b0, 1'b0, 8'd0);
    check("basic_valid_drop", 32'(valid_o), 32'd0);
    check("basic_hold", 32'(result_o), 32'd5050);
    check("basic_pulses", 32'(pulses), 32'd1);

    // Gapped input; valid_i on the run_i-low edge must be ignored
    pulses = 0;
    step(1'b1, 1'b1, 8'd10);
    step(1'b1, 1'b0, 8'd99);
    step(1'b1, 1'b1, 8'd20);
    step(1'b1, 1'b0, 8'd99);
    step(1'b1, 1'b0, 8'd99);
    step(1'b1, 1'b1, 8'd30);
    step(1'b0, 1'b1, 8'd99);
    check("gap_done_valid", 32'(valid_o), 32'd1);
    check("gap_sum", 32'(result_o), 32'd60);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("gap_pulses", 32'(pulses), 32'd1);

    // Overflow: 300 x 255 = 76500
    pulses = 0;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'd255);
    step(1'b0, 1'b0, 8'd0);
`ifdef ACC_CORE_SATURATE_EN
    check("ovf_sum", 32'(result_o), 32'd65535);
`else
    check("ovf_sum", 32'(result_o), 32'd10964);
`endif
    check("ovf_done_valid", 32'(valid_o), 32'd1);
    step(1'b0, 1'b0, 8'd0);

    // Reset mid-run
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'd7);
    check("rst_pre_sum", 32'(result_o), 32'd35);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'd7);
    rst = 1'b0;
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("rst_no_pulse", 32'(pulses), 32'd0);
    step(1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b1, 8'd2);
    step(1'b1, 1'b1, 8'd3);
    step(1'b0, 1'b0, 8'd0);
    check("rst_rerun_sum", 32'(result_o), 32'd6);
    check("rst_rerun_pulses", 32'(pulses), 32'd1);
    step(1'b0, 1'b0, 8'd0);

    // Back-to-back runs with run_i high through DONE
    pulses = 0;
    step(1'b1, 1'b1, 8'd4);
    step(1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b0, 8'd0);
    check("b2b_done1_valid", 32'(valid_o), 32'd1);
    check("b2b_done1_sum", 32'(result_o), 32'd9);
    step(1'b1, 1'b1, 8'd99);
    check("b2b_idle_hold", 32'(result_o), 32'd9);
    check("b2b_idle_valid", 32'(valid_o), 32'd0);
    step(1'b1, 1'b1, 8'd1);
    check("b2b_clear", 32'(result_o), 32'd1);
    step(1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b0, 8'd0);
    check("b2b_sum2", 32'(result_o), 32'd2);
    step(1'b0, 1'b0, 8'd0);
    check("b2b_pulses", 32'(pulses), 32'd2);

    // Single-edge run
    pulses = 0;
    step(1'b1, 1'b1, 8'd200);
    step(1'b0, 1'b0, 8'd0);
    check("single_valid", 32'(valid_o), 32'd1);
    check("single_sum", 32'(result_o), 32'd200);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_hold", 32'(result_o), 32'd200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
